// File: rtl/pio_mailbox_responder.sv
// pio_mailbox_responder: host PIO mailbox command responder; define PIO_MBOX_SEQ_EN for the response sequence counter
module pio_mailbox_responder #(
  parameter int NREGS       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_word,
  output logic [31:0] resp_word,
  input  logic [15:0] sw_in,
  output logic [15:0] out_a,
  output logic [15:0] out_b,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SETTLE, EXEC, RESPOND} state_t;
  localparam int AW = $clog2(NREGS);
  localparam logic [11:0] NREGS_A = 12'(NREGS);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] tog_sync_q, tog_sync_d;
  logic [SYNC_STAGES-1:0][15:0] sw_sync_q, sw_sync_d;
  logic [31:0] snap_q, snap_d, cmd_q, cmd_d, resp_q, resp_d;
  logic [NREGS-1:0][15:0] regs_q, regs_d;
  logic [15:0] result_q, result_d, result_n, cur, upd, data, sw_s;
  logic [1:0] status_q, status_d, status_n;
  logic last_tog_q, last_tog_d, tog_s, addr_ok, reg_op, wr;
  logic [2:0] op;
  logic [11:0] addr;
  logic [AW-1:0] idx;
  logic [7:0] seq_d;
  assign tog_sync_d = {tog_sync_q[SYNC_STAGES-2:0], cmd_word[31]};
  assign sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], sw_in};
  assign tog_s = tog_sync_q[SYNC_STAGES-1];
  assign sw_s = sw_sync_q[SYNC_STAGES-1];
  assign op = cmd_q[30:28];
  assign addr = cmd_q[27:16];
  assign data = cmd_q[15:0];
  assign idx = addr[AW-1:0];
  assign addr_ok = addr < NREGS_A;
  assign cur = regs_q[idx];
  assign reg_op = op >= 3'd1 && op <= 3'd5;
  assign wr = reg_op && op != 3'd2 && addr_ok;
  assign upd = op == 3'd1 ? data : op == 3'd3 ? (cur | data) : op == 3'd4 ? (cur & ~data) : cur + data;
  assign status_n = op == 3'd7 ? 2'b01 : (reg_op && !addr_ok) ? 2'b10 : 2'b00;
  assign result_n = status_n != 2'b00 ? 16'h0 : op == 3'd6 ? sw_s : op == 3'd2 ? cur : op == 3'd0 ? 16'h0 : upd;
`ifdef PIO_MBOX_SEQ_EN
  logic [7:0] seq_q;
  assign seq_d = state_q == RESPOND ? seq_q + 8'd1 : seq_q;
  always_ff @(posedge clk)
    seq_q <= reset ? 8'd0 : seq_d;
`else
  assign seq_d = 8'd0;
`endif
  always_comb begin
    state_d = state_q;
    snap_d = snap_q;
    cmd_d = cmd_q;
    last_tog_d = last_tog_q;
    regs_d = regs_q;
    status_d = status_q;
    result_d = result_q;
    resp_d = resp_q;
    case (state_q)
      IDLE: begin
        snap_d = tog_s != last_tog_q ? cmd_word : snap_q;
        state_d = tog_s != last_tog_q ? SETTLE : IDLE;
      end
      SETTLE: begin
        snap_d = cmd_word;
        if (cmd_word == snap_q) begin
          cmd_d = snap_q;
          state_d = snap_q[31] == last_tog_q ? IDLE : EXEC;
        end
      end
      EXEC: begin
        status_d = status_n;
        result_d = result_n;
        if (wr) regs_d[idx] = upd;
        state_d = RESPOND;
      end
      default: begin
        resp_d = {cmd_q[31], status_q, 5'b0, seq_d, result_q};
        last_tog_d = cmd_q[31];
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tog_sync_q <= '0;
      sw_sync_q <= '0;
      snap_q <= '0;
      cmd_q <= '0;
      resp_q <= '0;
      regs_q <= '0;
      status_q <= '0;
      result_q <= '0;
      last_tog_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tog_sync_q <= tog_sync_d;
      sw_sync_q <= sw_sync_d;
      snap_q <= snap_d;
      cmd_q <= cmd_d;
      resp_q <= resp_d;
      regs_q <= regs_d;
      status_q <= status_d;
      result_q <= result_d;
      last_tog_q <= last_tog_d;
    end
  end
  assign resp_word = resp_q;
  assign out_a = regs_q[0];
  assign out_b = regs_q[1];
  assign busy = state_q != IDLE;
endmodule
